// File: rtl/axis_eth_fcs_check_pkg.sv
// Shared Ethernet CRC constants and common types for the FCS checker.
// The polynomial, init value and residue are also used by the FCS inserter.
package axis_eth_fcs_check_pkg;

   localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

   // Length of the trailing FCS field, which is also the depth of the delay line.
   localparam int FCS_BYTES = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_PAYLOAD
   } fcs_state_t;

   // One output beat as it travels through the skid buffer.
   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } axis_beat_t;

endpackage

// File: rtl/axis_eth_fcs_check_lfsr.sv
// Combinational Galois LFSR step over one data word.
// REVERSE=1 processes data LSB first and shifts right with the bit-reversed
// polynomial, which is the reflected form used by the Ethernet CRC-32.
module axis_eth_fcs_check_lfsr
   import axis_eth_fcs_check_pkg::*;
#(
   parameter int                    LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = ETH_CRC_POLY,
   parameter bit                    REVERSE    = 1'b1,
   parameter int                    DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] state_in,
   output logic [LFSR_WIDTH-1:0] state_out
);

   logic [LFSR_WIDTH-1:0] poly_rev;

   // Bit-reversed polynomial for the reflected shift direction.
   always_comb begin
      for (int i = 0; i < LFSR_WIDTH; i++) begin
         poly_rev[i] = LFSR_POLY[LFSR_WIDTH-1-i];
      end
   end

   // Advance the state once per data bit, feeding back through the polynomial taps.
   always_comb begin
      // NOTE: full default before the loop, so no path leaves state_out unassigned (no latch).
      state_out = state_in;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (REVERSE) begin
            if (state_out[0] ^ data_in[i]) state_out = (state_out >> 1) ^ poly_rev;
            else                           state_out = state_out >> 1;
         end else begin
            if (state_out[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i]) state_out = (state_out << 1) ^ LFSR_POLY;
            else                                                   state_out = state_out << 1;
         end
      end
   end

endmodule

// File: rtl/axis_eth_fcs_check.sv
// AXI-Stream Ethernet FCS checker: strips the trailing 4-byte FCS through a
// 4-byte delay line, checks the CRC-32 residue and flags bad frames on tuser
// of the last beat. Short frames are dropped. Output goes through a 2-entry
// skid buffer so the input runs at full throughput with registered tready.
module axis_eth_fcs_check
   import axis_eth_fcs_check_pkg::*;
#(
   parameter int MIN_FRAME_LENGTH = 5
) (
   input  logic       clk,
   input  logic       rst_n,

   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,

   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,

   output logic       busy,
   output logic       error_bad_fcs,
   output logic       error_short
);

   localparam int               LEN_W   = $clog2(MIN_FRAME_LENGTH + 1);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MIN_FRAME_LENGTH);

   fcs_state_t       state;
   logic [2:0]       fill_cnt;
   logic [LEN_W-1:0] len_cnt;
   logic [31:0]      crc;
   logic [31:0]      crc_next;
   logic [7:0]       dly [FCS_BYTES];

   logic             s_ready_reg;
   logic             ready_early;
   axis_beat_t       out_beat;
   axis_beat_t       tmp_beat;
   axis_beat_t       int_beat;
   logic             out_valid;
   logic             tmp_valid;
   logic             int_valid;

   logic             accept;
   logic             is_short;
   logic             fcs_bad;

   assign accept   = s_axis_tvalid && s_ready_reg;
   // Short means the delay line never filled, or (for larger minimums) too few bytes counted.
   assign is_short = (state != ST_PAYLOAD) || ((int'(len_cnt) + 1) < MIN_FRAME_LENGTH);
   assign fcs_bad  = (crc_next != ETH_CRC_RESIDUE);

   axis_eth_fcs_check_lfsr #(
      .LFSR_WIDTH (32),
      .LFSR_POLY  (ETH_CRC_POLY),
      .REVERSE    (1'b1),
      .DATA_WIDTH (8)
   ) crc_lfsr (
      .data_in   (s_axis_tdata),
      .state_in  (crc),
      .state_out (crc_next)
   );

   // Beat leaving the delay line; only a full delay line produces output.
   assign int_valid = accept && (state == ST_PAYLOAD);

   // Assemble the delayed beat, flagging the last one when the frame is bad.
   always_comb begin
      int_beat      = '0;
      int_beat.data = dly[FCS_BYTES-1];
      int_beat.last = s_axis_tlast;
      int_beat.user = s_axis_tlast && (s_axis_tuser || fcs_bad || is_short);
   end

   // Frame FSM, CRC state, length tracking, busy and one-cycle error pulses.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state         <= ST_IDLE;
         fill_cnt      <= '0;
         len_cnt       <= '0;
         crc           <= ETH_CRC_INIT;
         busy          <= 1'b0;
         error_bad_fcs <= 1'b0;
         error_short   <= 1'b0;
      end else begin
         error_bad_fcs <= 1'b0;
         error_short   <= 1'b0;
         if (accept) begin
            if (s_axis_tlast) begin
               state         <= ST_IDLE;
               fill_cnt      <= '0;
               len_cnt       <= '0;
               crc           <= ETH_CRC_INIT;
               busy          <= 1'b0;
               error_short   <= is_short;
               error_bad_fcs <= !is_short && !s_axis_tuser && fcs_bad;
            end else begin
               crc  <= crc_next;
               busy <= 1'b1;
               if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 1'b1;
               case (state)
                  ST_IDLE: begin
                     state    <= ST_FILL;
                     fill_cnt <= 3'd1;
                  end
                  ST_FILL: begin
                     fill_cnt <= fill_cnt + 3'd1;
                     if (fill_cnt == 3'd3) state <= ST_PAYLOAD;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Delay line shifts on every accepted byte; the oldest byte is the outgoing beat.
   // NOTE: storage is deliberately unreset; fill_cnt/state decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         dly[0] <= s_axis_tdata;
         for (int i = 1; i < FCS_BYTES; i++) dly[i] <= dly[i-1];
      end
   end

   // Input tready may only drop when the temp slot is about to fill.
   assign ready_early = m_axis_tready || (!tmp_valid && (!out_valid || !int_valid));

   // Two-entry skid buffer: output register plus temp register behind it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_ready_reg <= 1'b0;
         out_valid   <= 1'b0;
         out_beat    <= '0;
         tmp_valid   <= 1'b0;
      end else begin
         s_ready_reg <= ready_early;
         if (s_ready_reg) begin
            if (m_axis_tready || !out_valid) begin
               out_valid <= int_valid;
               if (int_valid) out_beat <= int_beat;
            end else begin
               tmp_valid <= int_valid;
               tmp_beat  <= int_beat;
            end
         end else if (m_axis_tready) begin
            out_valid <= tmp_valid;
            if (tmp_valid) out_beat <= tmp_beat;
            tmp_valid <= 1'b0;
         end
      end
   end

   assign s_axis_tready = s_ready_reg;
   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_beat.data;
   assign m_axis_tlast  = out_beat.last;
   assign m_axis_tuser  = out_beat.user;

endmodule

// File: tb/tb_axis_eth_fcs_check.sv
// Directed bench for the FCS checker: known CRC vector, corrupted frame,
// short frame, upstream error, back-to-back frames under random backpressure,
// and a mid-frame reset. A queue of expected beats is filled from each frame.
module tb_axis_eth_fcs_check;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_axis_tdata = '0;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic       s_axis_tuser = 1'b0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;
   logic       m_axis_tlast;
   logic       m_axis_tuser;
   logic       busy;
   logic       error_bad_fcs;
   logic       error_short;

   axis_eth_fcs_check #(.MIN_FRAME_LENGTH(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .busy          (busy),
      .error_bad_fcs (error_bad_fcs),
      .error_short   (error_short)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] tx[$];
   logic [9:0] exp_q[$];
   int         beat_cnt  = 0;
   int         bad_cnt   = 0;
   int         short_cnt = 0;
   bit         ignore_mode = 1'b0;
   bit         rand_ready  = 1'b0;
   bit         prev_stall  = 1'b0;
   logic [9:0] prev_beat   = '0;

   // Backpressure driver.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: scoreboard, stall stability and error pulse counting.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(m_axis_tvalid), 1);
            check("stall_hold", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(prev_beat));
         end
         if (error_bad_fcs) bad_cnt++;
         if (error_short) short_cnt++;
         if (m_axis_tvalid && m_axis_tready) begin
            beat_cnt++;
            if (ignore_mode)           check("aborted_frame_tlast", 32'(m_axis_tlast), 0);
            else if (exp_q.size() == 0) check("unexpected_beat", 32'(m_axis_tvalid), 0);
            else check("beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'(exp_q.pop_front()));
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      end
   end

   // Reference FCS over the current tx contents (bitwise reflected CRC-32, complemented).
   function automatic logic [31:0] fcs_of_tx();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (tx[i]) begin
         c ^= {24'd0, tx[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic make_frame(input int len);
      logic [31:0] f;
      tx.delete();
      for (int i = 0; i < len - 4; i++) tx.push_back(8'($urandom));
      f = fcs_of_tx();
      for (int i = 0; i < 4; i++) tx.push_back(f[8*i +: 8]);
   endtask

   // Expected output: every byte except the FCS, tlast on the final payload byte.
   task automatic expect_tx(input bit user);
      int n;
      n = tx.size() - 4;
      for (int i = 0; i < n; i++) exp_q.push_back({tx[i], 1'(i == n - 1), 1'((i == n - 1) && user)});
   endtask

   // Send the first cnt bytes of tx; tlast goes with the final byte of tx.
   task automatic send_tx(input bit user_last, input int cnt);
      int n;
      int wait_cyc;
      n = tx.size();
      for (int i = 0; i < cnt; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = tx[i];
         s_axis_tlast  = (i == n - 1);
         s_axis_tuser  = (i == n - 1) ? user_last : 1'b0;
         wait_cyc = 0;
         @(negedge clk);
         while (!s_axis_tready && wait_cyc < 1000) begin
            @(negedge clk);
            wait_cyc++;
         end
         if (!s_axis_tready) begin
            check("s_tready_timeout", 32'(s_axis_tready), 1);
            s_axis_tvalid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (i == 0) check("busy_start", 32'(busy), 32'(n > 1));
      end
      // Idle garbage on the qualifiers must be ignored while tvalid is low.
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'hA5;
      s_axis_tlast  = 1'b1;
      s_axis_tuser  = 1'b1;
      if (cnt == n) check("busy_end", 32'(busy), 0);
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 5000) begin
         @(posedge clk);
         cyc++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_tready"}, 32'(s_axis_tready), 0);
      check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 0);
      check({tag, "_m_tdata"},  32'(m_axis_tdata), 0);
      check({tag, "_m_tlast"},  32'(m_axis_tlast), 0);
      check({tag, "_m_tuser"},  32'(m_axis_tuser), 0);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_bad_fcs"},  32'(error_bad_fcs), 0);
      check({tag, "_short"},    32'(error_short), 0);
   endtask

   initial begin
      int b0, e0, s0, total;
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, e0, s0, total;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // "123456789" with its FCS, no backpressure.
      tx = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      expect_tx(1'b0);
      send_tx(1'b0, tx.size());
      wait_drain();
      check("good_beats", beat_cnt - b0, 9);
      check("good_bad_fcs", bad_cnt - e0, 0);
      check("good_short", short_cnt - s0, 0);

      // Same frame, byte 3 bit 0 flipped.
      tx = '{8'h31, 8'h32, 8'h32, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      expect_tx(1'b1);
      send_tx(1'b0, tx.size());
      wait_drain();
      check("corrupt_beats", beat_cnt - b0, 9);
      check("corrupt_bad_fcs", bad_cnt - e0, 1);
      check("corrupt_short", short_cnt - s0, 0);

      // 3-byte short frame, then a valid 64-byte frame.
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      tx = '{8'h01, 8'h02, 8'h03};
      send_tx(1'b0, 3);
      make_frame(64);
      expect_tx(1'b0);
      send_tx(1'b0, 64);
      wait_drain();
      check("short_then_good_beats", beat_cnt - b0, 60);
      check("short_pulses", short_cnt - s0, 1);
      check("short_bad_fcs", bad_cnt - e0, 0);

      // Valid frame flagged upstream on tlast.
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      make_frame(64);
      expect_tx(1'b1);
      send_tx(1'b1, 64);
      wait_drain();
      check("tuser_beats", beat_cnt - b0, 60);
      check("tuser_bad_fcs", bad_cnt - e0, 0);
      check("tuser_short", short_cnt - s0, 0);

      // 100 back-to-back frames under random backpressure.
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      total = 0;
      rand_ready = 1'b1;
      for (int f = 0; f < 100; f++) begin
         make_frame(int'($urandom_range(5, 40)));
         total += tx.size() - 4;
         expect_tx(1'b0);
         send_tx(1'b0, tx.size());
      end
      wait_drain();
      rand_ready = 1'b0;
      check("b2b_beats", beat_cnt - b0, total);
      check("b2b_bad_fcs", bad_cnt - e0, 0);
      check("b2b_short", short_cnt - s0, 0);

      // Reset at byte 20 of a 64-byte frame, then a valid 10-byte frame.
      ignore_mode = 1'b1;
      make_frame(64);
      send_tx(1'b0, 20);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_reset_outputs("midreset");
      ignore_mode = 1'b0;
      b0 = beat_cnt; e0 = bad_cnt; s0 = short_cnt;
      make_frame(10);
      expect_tx(1'b0);
      send_tx(1'b0, 10);
      wait_drain();
      check("after_reset_beats", beat_cnt - b0, 6);
      check("after_reset_bad_fcs", bad_cnt - e0, 0);
      check("after_reset_short", short_cnt - s0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_eth_fcs_check.md
AXIS_ETH_FCS_CHECK -- requirements
Module: axis_eth_fcs_check

Interface
REQ-001 SHALL have parameter MIN_FRAME_LENGTH, default 5: minimum accepted frame length in bytes, FCS included; legal values are 5 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port s_axis_tdata/tvalid/tready/tlast/tuser, in/in/out/in/in, 8/1/1/1/1 bits: received frame with trailing 4-byte FCS; tuser is sampled with tlast (upstream error).
REQ-005 SHALL have port m_axis_tdata/tvalid/tready/tlast/tuser, out/out/in/out/out, 8/1/1/1/1 bits: frame with FCS stripped; tuser is set on the last byte if the frame is bad.
REQ-006 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-007 SHALL have port error_bad_fcs, output, 1 bit: one-cycle pulse on an FCS mismatch.
REQ-008 SHALL have port error_short, output, 1 bit: one-cycle pulse when a short frame is dropped.

Function
REQ-009 SHALL compute CRC-32 (poly 32'h04C11DB7, reflected, Galois, init 32'hFFFFFFFF) over every accepted input byte, FCS bytes included.
REQ-010 SHALL declare the FCS good when the CRC state after the tlast byte equals the residue 32'hDEBB20E3.
REQ-011 SHALL hold a 4-byte delay line; each accepted input byte after the 4th pushes out the byte accepted 4 beats earlier as one output beat.
REQ-012 SHALL produce no output for the first 4 bytes of a frame (fill phase).
REQ-013 SHALL, on accepting the input tlast byte, emit the delayed byte (the last payload byte) with m_axis_tlast=1.
REQ-014 SHALL set m_axis_tuser on that last beat to s_axis_tuser OR (FCS bad); it then discards the delay line and resets the CRC to 32'hFFFFFFFF.
REQ-015 SHALL keep m_axis_tuser=0 on all non-last beats.
REQ-016 SHALL pulse error_bad_fcs in the cycle after a tlast byte whose CRC check fails; no pulse is generated when s_axis_tuser=1.
REQ-017 SHALL drop a frame whose total length is below MIN_FRAME_LENGTH: no output beats, delay line cleared, error_short pulsed the cycle after its tlast.
REQ-018 SHALL implement the state machine IDLE -> FILL -> PAYLOAD -> IDLE, with a 3-bit fill counter (0..4):
- IDLE, first byte accepted: go to FILL.
- FILL: go to PAYLOAD when the count reaches 4.
- Any state, tlast accepted: go to IDLE.
- tlast in IDLE or FILL means a short frame.
REQ-019 SHALL accept a tlast byte in IDLE as a 1-byte frame, which is short.
REQ-020 SHALL drive s_axis_tready from the registered early-ready of a 2-entry output skid buffer (output register plus temp register) in all states.
REQ-021 SHALL give a full-throughput path from input transfer to m_axis_tvalid with 1 cycle of register latency, plus the 4-beat frame delay.
REQ-022 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 SHALL not lose, duplicate or reorder a beat under any m_axis_tready pattern.
REQ-024 SHALL assert busy from the cycle after the first byte is accepted until the cycle after tlast is accepted.
REQ-025 SHALL ignore s_axis_tdata/tlast/tuser when s_axis_tvalid=0 or s_axis_tready=0.
REQ-026 SHALL keep a frame's last beat held in the output register while m_axis_tready=0, and SHALL still accept the next frame's fill bytes into the delay line (back-to-back frames).

Reset
REQ-027 SHALL, with rst_n=0 at a clock edge, drive s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, error_bad_fcs=0 and error_short=0 from the next cycle.
REQ-028 SHALL, on the same reset, set the state to IDLE, the fill count to 0, the CRC to 32'hFFFFFFFF, and empty the skid buffer.
REQ-029 SHALL discard a frame interrupted by reset mid-frame with no tlast emitted; bytes after reset release start a new frame.

Structure
REQ-030 SHALL place the CRC polynomial 32'h04C11DB7, the init value 32'hFFFFFFFF and the residue 32'hDEBB20E3 in the shared Ethernet CRC constants header, which this block and the FCS inserter both use.
REQ-031 SHALL instantiate exactly one sub-module, the existing lfsr (32-bit, 8-bit data, GALOIS, REVERSE=1), for the CRC; the FSM, delay line and skid buffer are local logic.

Verification
REQ-032 SHALL cover: ASCII "123456789" followed by 26 39 F4 CB, with m_axis_tready=1 -> 9 bytes "123456789" out, tlast on '9', tuser=0, no error pulses.
REQ-033 SHALL cover: the same frame with byte 3 bit 0 flipped -> 9 bytes out, tlast with tuser=1, exactly one error_bad_fcs pulse.
REQ-034 SHALL cover: a 3-byte frame, then a valid 64-byte frame -> zero beats for the first, one error_short pulse, then 60 beats with a correct tlast.
REQ-035 SHALL cover: a valid 64-byte frame with s_axis_tuser=1 on tlast -> 60 beats, tuser=1, no error_bad_fcs.
REQ-036 SHALL cover: 100 back-to-back valid frames with a random m_axis_tready (50%) -> byte-exact payload stream, no drops, stable data while stalled.
REQ-037 SHALL cover: rst_n=0 for 1 cycle at byte 20 of a 64-byte frame, then a valid 10-byte frame -> no tlast for the first frame, 6 beats with tuser=0 for the second.
